// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, instruction
// width and the size of one prefetch-queue entry.
package cpu_pkg;

  localparam int INSTRUCTION_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // A queue entry holds the instruction word above the address it was fetched from.
  function automatic int fetch_entry_width(input int addr_width);
    return INSTRUCTION_WIDTH + addr_width;
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction memory read channel: one request/address, completed by ready with data.
interface cpu_fetch_if import cpu_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                         o_bus_request;
  logic [ADDR_WIDTH-1:0]        o_bus_address;
  logic                         i_bus_ready;
  logic [INSTRUCTION_WIDTH-1:0] i_bus_data;

  modport master (
    output o_bus_request,
    output o_bus_address,
    input  i_bus_ready,
    input  i_bus_data
  );

  modport slave (
    input  o_bus_request,
    input  o_bus_address,
    output i_bus_ready,
    output i_bus_data
  );

endinterface

// File: rtl/cpu_fetch_fifo.sv
// Synchronous prefetch queue with push, pop and flush; flush beats push and pop.
module cpu_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == DEPTH_COUNT);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only visible once count covers it.
  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: one outstanding memory read at a time feeding a prefetch
// queue, with redirect (jump) that flushes the queue and drops in-flight data.
module cpu_fetch import cpu_pkg::*; #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  cpu_fetch_if.master                  bus,
  input  logic                         i_jump,
  input  logic [ADDR_WIDTH-1:0]        i_jump_pc,
  output logic                         o_valid,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]        o_pc,
  input  logic                         i_ready,
  output logic [$clog2(FIFO_DEPTH):0]  o_count
);

  localparam int ENTRY_WIDTH = fetch_entry_width(ADDR_WIDTH);

  fetch_state_t           state;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  jump_target;
  logic [ENTRY_WIDTH-1:0] head;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;

  assign jump_target = i_jump_pc & ~ADDR_WIDTH'(3);
  // A word returning in the same cycle as a jump belongs to the old stream.
  assign push = (state == REQUEST) && bus.i_bus_ready && !i_jump;
  assign pop  = !empty && i_ready;

  cpu_fetch_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (i_jump),
    .i_data  ({bus.i_bus_data, fetch_pc}),
    .o_data  (head),
    .o_empty (empty),
    .o_full  (full),
    .o_count (o_count)
  );

  assign o_valid       = !empty;
  assign o_instruction = head[ENTRY_WIDTH-1 -: INSTRUCTION_WIDTH];
  assign o_pc          = head[ADDR_WIDTH-1:0];

  // NOTE: state and outputs use non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      fetch_pc          <= RESET_PC;
      bus.o_bus_request <= 1'b0;
      bus.o_bus_address <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_jump) begin
            fetch_pc <= jump_target;
          end else if (!full) begin
            state             <= REQUEST;
            bus.o_bus_request <= 1'b1;
            bus.o_bus_address <= fetch_pc;
          end
        end
        REQUEST: begin
          if (i_jump) begin
            fetch_pc <= jump_target;
            if (bus.i_bus_ready) begin
              state             <= IDLE;
              bus.o_bus_request <= 1'b0;
            end else begin
              // Request stays on the bus until memory completes it; its data is then dropped.
              state <= DISCARD;
            end
          end else if (bus.i_bus_ready) begin
            state             <= IDLE;
            fetch_pc          <= fetch_pc + ADDR_WIDTH'(4);
            bus.o_bus_request <= 1'b0;
          end
        end
        DISCARD: begin
          if (i_jump) fetch_pc <= jump_target;
          if (bus.i_bus_ready) begin
            state             <= IDLE;
            bus.o_bus_request <= 1'b0;
          end
        end
        default: begin
          state             <= IDLE;
          bus.o_bus_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios plus randomized traffic
// scored against a transaction-level model of the fetch stream and queue.
module tb_cpu_fetch;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RST_PC  = 32'h0000_0000;
  localparam logic [AW-1:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  logic          i_reset;
  logic          i_jump;
  logic [AW-1:0] i_jump_pc;
  logic          i_ready;
  logic          o_valid;
  logic [31:0]   o_instruction;
  logic [AW-1:0] o_pc;
  logic [CW-1:0] o_count;

  cpu_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  cpu_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .bus           (bus.master),
    .i_jump        (i_jump),
    .i_jump_pc     (i_jump_pc),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .o_count       (o_count)
  );

  // Second instance: reset vector near the top of the address space, memory always ready.
  cpu_fetch_if #(.ADDR_WIDTH(AW)) bus_w ();
  logic          w_valid;
  logic [31:0]   w_instruction;
  logic [AW-1:0] w_pc;
  logic [CW-1:0] w_count;
  logic [AW-1:0] wrap_q[$];

  assign bus_w.i_bus_ready = bus_w.o_bus_request;
  assign bus_w.i_bus_data  = 32'h0000_0013;

  cpu_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .bus           (bus_w.master),
    .i_jump        (1'b0),
    .i_jump_pc     ('0),
    .o_valid       (w_valid),
    .o_instruction (w_instruction),
    .o_pc          (w_pc),
    .i_ready       (1'b1),
    .o_count       (w_count)
  );

  always @(negedge i_clock) begin
    if (!i_reset && bus_w.o_bus_request && bus_w.i_bus_ready && wrap_q.size() < 3)
      wrap_q.push_back(bus_w.o_bus_address);
  end

  // Reference model state
  entry_t        mq[$];
  logic [AW-1:0] m_pc;
  bit            m_discard;
  int            wait_cnt;
  int            mem_wait;
  bit            rand_lat;
  bit            nop_data;
  bit            idle_ready;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the DUT take the edge, advance the model, compare.
  task automatic step(input bit jump, input logic [AW-1:0] jpc, input bit pop);
    bit            req;
    bit            rdy;
    bit            rst;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    req  = bus.o_bus_request;
    addr = bus.o_bus_address;
    rst  = i_reset;
    rdy  = req ? (wait_cnt >= mem_wait) : idle_ready;
    data = nop_data ? 32'h0000_0013 : mem_word(addr);
    i_jump           = jump;
    i_jump_pc        = jpc;
    i_ready          = pop;
    bus.i_bus_ready  = rdy;
    bus.i_bus_data   = data;
    @(posedge i_clock);
    if (rst) begin
      mq.delete();
      m_pc      = RST_PC;
      m_discard = 0;
      wait_cnt  = 0;
    end else begin
      if (req && rdy) begin
        if (!m_discard) check("req_addr", addr, m_pc);
        wait_cnt = 0;
        if (rand_lat) mem_wait = $urandom_range(0, 3);
      end else if (req) begin
        wait_cnt++;
      end
      if (jump) begin
        mq.delete();
        m_pc = {jpc[AW-1:2], 2'b00};
        if (req) m_discard = !rdy;
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (req && rdy) begin
          if (!m_discard) begin
            mq.push_back('{instr: data, pc: addr});
            m_pc = addr + 32'd4;
          end
          m_discard = 0;
        end
      end
    end
    @(negedge i_clock);
    check("valid", o_valid, mq.size() != 0);
    check("count", o_count, mq.size());
    if (mq.size() > 0) begin
      check("head_instr", o_instruction, mq[0].instr);
      check("head_pc", o_pc, mq[0].pc);
    end
    if (rst) begin
      check("rst_req", bus.o_bus_request, 1'b0);
      check("rst_addr", bus.o_bus_address, RST_PC);
    end else if (req && !rdy) begin
      check("req_hold", bus.o_bus_request, 1'b1);
      check("addr_hold", bus.o_bus_address, addr);
    end else if (req && rdy) begin
      check("req_gap", bus.o_bus_request, 1'b0);
    end
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!bus.o_bus_request && n < max_cycles) begin
      step(0, '0, 0);
      n++;
    end
    check("req_timeout", bus.o_bus_request, 1'b1);
  endtask

  initial begin
    i_reset         = 1'b1;
    i_jump          = 1'b0;
    i_jump_pc       = '0;
    i_ready         = 1'b0;
    bus.i_bus_ready = 1'b0;
    bus.i_bus_data  = '0;
    m_pc            = RST_PC;
    m_discard       = 0;
    wait_cnt        = 0;
    mem_wait        = 0;
    rand_lat        = 0;
    nop_data        = 1;
    idle_ready      = 0;
    @(negedge i_clock);

    // Reset state, then fill the queue with NOPs while decode stalls
    step(0, '0, 0);
    step(0, '0, 0);
    check("reset_valid", o_valid, 1'b0);
    check("reset_count", o_count, 0);
    check("reset_req", bus.o_bus_request, 1'b0);
    i_reset = 1'b0;
    step(0, '0, 0);
    check("first_req", bus.o_bus_request, 1'b1);
    check("first_addr", bus.o_bus_address, RST_PC);
    for (int i = 0; i < 11; i++) step(0, '0, 0);
    check("full_count", o_count, 4);
    check("full_head_pc", o_pc, 32'h0);
    check("full_head_instr", o_instruction, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0);
      check("full_no_req", bus.o_bus_request, 1'b0);
    end

    // One pop from a full queue triggers exactly one refill at 0x10
    step(0, '0, 1);
    check("pop_count", o_count, 3);
    wait_req(10);
    check("refill_addr", bus.o_bus_address, 32'h10);
    step(0, '0, 0);
    check("refill_count", o_count, 4);

    // Jump while the request to 0x8 is stalled
    step(1, 32'h8, 0);
    check("jump_idle_count", o_count, 0);
    mem_wait = 5;
    wait_req(10);
    check("stall_addr", bus.o_bus_address, 32'h8);
    step(0, '0, 0);
    step(0, '0, 0);
    step(1, 32'h200, 0);
    check("discard_req_held", bus.o_bus_request, 1'b1);
    for (int i = 0; i < 12 && bus.o_bus_request; i++) step(0, '0, 0);
    check("discard_done", bus.o_bus_request, 1'b0);
    check("discard_count", o_count, 0);
    mem_wait = 0;
    wait_req(10);
    check("jump_addr", bus.o_bus_address, 32'h200);
    step(0, '0, 0);
    check("jump_first_pc", o_pc, 32'h200);

    // Jump together with bus ready and a pop: flush wins, word dropped
    wait_req(10);
    check("combo_valid_before", o_valid, 1'b1);
    step(1, 32'h103, 1);
    check("combo_count", o_count, 0);
    check("combo_valid", o_valid, 1'b0);
    wait_req(10);
    check("combo_next_addr", bus.o_bus_address, 32'h100);

    // Reset in the middle of a request with ready arriving the same cycle
    i_reset    = 1'b1;
    idle_ready = 1;
    step(0, '0, 0);
    check("midrst_count", o_count, 0);
    step(0, '0, 0);
    i_reset = 1'b0;
    step(0, '0, 0);
    idle_ready = 0;
    check("midrst_count_after", o_count, 0);
    check("midrst_req", bus.o_bus_request, 1'b1);
    check("midrst_addr", bus.o_bus_address, RST_PC);

    // Address wrap on the second instance
    check("wrap_seen", wrap_q.size() >= 3, 1'b1);
    if (wrap_q.size() >= 3) begin
      check("wrap_addr0", wrap_q[0], 32'hFFFF_FFF8);
      check("wrap_addr1", wrap_q[1], 32'hFFFF_FFFC);
      check("wrap_addr2", wrap_q[2], 32'h0000_0000);
    end

    // Randomized traffic: jumps, pops, variable latency and occasional reset
    nop_data = 0;
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      i_reset = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 1) == 1);
    end
    i_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address/PC signals.
REQ-002 Parameter FIFO_DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset; bits [1:0] zero.
REQ-004 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 o_bus_request  out  1  instruction read request to memory.
REQ-007 o_bus_address  out  ADDR_WIDTH  read address; word aligned.
REQ-008 i_bus_ready  in  1  memory has completed the current request; i_bus_data valid.
REQ-009 i_bus_data  in  32  instruction word returned by memory.
REQ-010 i_jump  in  1  redirect fetch stream (branch, jump, trap).
REQ-011 i_jump_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as zero.
REQ-012 o_valid  out  1  head queue entry available to decode.
REQ-013 o_instruction  out  32  head instruction word.
REQ-014 o_pc  out  ADDR_WIDTH  address of the head instruction.
REQ-015 i_ready  in  1  decode accepts the head entry when o_valid is high (pop).
REQ-016 o_count  out  clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-017 The block SHALL use states IDLE, REQUEST and DISCARD, with at most one outstanding bus request.
REQ-018 IDLE -> REQUEST when o_count < FIFO_DEPTH and i_jump is low: assert o_bus_request, drive o_bus_address = fetch_pc.
REQ-019 In REQUEST, o_bus_request and o_bus_address SHALL be held stable until i_bus_ready is sampled high.
REQ-020 On REQUEST with i_bus_ready high: push {i_bus_data, fetch_pc}, fetch_pc += 4 modulo 2^ADDR_WIDTH, deassert request next cycle, go to IDLE.
REQ-021 Successive requests SHALL be separated by at least one cycle with o_bus_request low.
REQ-022 A pushed entry SHALL appear on o_valid/o_instruction/o_pc on the cycle after i_bus_ready.
REQ-023 A pop SHALL occur on a cycle with o_valid and i_ready both high; o_instruction/o_pc SHALL be held stable while o_valid is high and i_ready is low.
REQ-024 A simultaneous push and pop SHALL leave o_count unchanged and preserve FIFO order.
REQ-025 The queue SHALL never overflow: a request is issued only when a free slot exists, and only one request is in flight.
REQ-026 When i_jump is high in IDLE: flush the queue, fetch_pc = {i_jump_pc[ADDR_WIDTH-1:2], 2'b00}, stay in IDLE for that cycle.
REQ-027 When i_jump is high in REQUEST without i_bus_ready: flush the queue, load fetch_pc, go to DISCARD with o_bus_request still held.
REQ-028 In DISCARD, i_bus_ready high SHALL drop i_bus_data (no push), deassert request and go to IDLE.
REQ-029 When i_jump coincides with i_bus_ready in REQUEST, the returned word SHALL be dropped, the queue flushed and the state SHALL become IDLE with the new fetch_pc.
REQ-030 When i_jump coincides with a pop, the flush SHALL win: o_valid low and o_count 0 next cycle.
REQ-031 When i_jump is high in DISCARD, only fetch_pc SHALL update (last jump wins) and the queue SHALL be flushed again.

Reset
REQ-032 While i_reset is high: state IDLE, fetch_pc RESET_PC, o_bus_request 0, o_bus_address RESET_PC, queue empty, o_valid 0, o_count 0.
REQ-033 Reset during REQUEST/DISCARD SHALL abandon the transaction; i_bus_ready after reset is ignored in IDLE.
REQ-034 The first request SHALL assert on the first rising edge with i_reset low, fetching RESET_PC.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the fetch state encoding, INSTRUCTION_WIDTH = 32 and the fetch-entry record width.
REQ-036 Queue SHALL be sub-module cpu_fetch_fifo: synchronous FIFO with push, pop, flush and count; flush has priority over push/pop.

Verification
REQ-037 Reset, memory returns 0x00000013 at 0, 4, 8, 12 with 1-cycle ready, i_ready low -> four entries, o_count 4, request stops; o_pc 0 with head 0x00000013.
REQ-038 Full queue (FIFO_DEPTH 4), pulse i_ready one cycle -> o_count 3, then one new request to 0x10, o_count back to 4.
REQ-039 i_jump with i_jump_pc 0x200 while request to 0x8 is stalled 5 cycles -> data from 0x8 dropped, next request address 0x200, first o_pc 0x200.
REQ-040 i_jump with i_jump_pc 0x103 coincident with i_bus_ready and pop -> o_count 0 next cycle, next fetch address 0x100.
REQ-041 RESET_PC 0xFFFFFFF8, continuous ready -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
REQ-042 Assert i_reset mid-REQUEST with ready arriving the same cycle -> no push, o_count 0, next request to RESET_PC.
